lights_nios2_qsys_0_ocimem_arbiter: RTL and testbench
=====================================================

# lights_nios2_qsys_0_ocimem_arbiter

Arbitrates the Nios II on-chip debug memory (OCI RAM, 256 x 32, single port) between two requesters: the JTAG debug path, which issues single-cycle command strobes from the sysclk-side JTAG decoder, and the CPU's Avalon debug slave port. The block owns all RAM control signals, serialises accesses through a 4-state FSM, and applies round-robin fairness. It sits between the JTAG debug-module wrapper outputs and the OCI RAM instance inside the Nios II core.

## Interface
- No parameters. Data width is fixed at 32 bits, address width at 8 bits, and RAM read latency at 1 cycle.
- Clocking and reset: one clock `clk`; reset is synchronous and active-high, port `reset`.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jtag_req  in  1  single-cycle command strobe (from take_action_ocimem_*)
- jtag_wr  in  1  1 = write, 0 = read; sampled with jtag_req
- jtag_addr  in  8  word address; sampled with jtag_req
- jtag_wdata  in  32  write data; sampled with jtag_req
- jtag_rdata  out  32  read data; valid while jtag_done=1 and held until the next JTAG completion
- jtag_done  out  1  one-cycle completion pulse
- jtag_busy  out  1  JTAG command pending or in flight
- jtag_overrun  out  1  sticky flag: a strobe was dropped; cleared only by reset
- av_read  in  1  Avalon read
- av_write  in  1  Avalon write
- av_address  in  8  Avalon word address
- av_writedata  in  32  Avalon write data
- av_debugaccess  in  1  privileged-access qualifier
- av_readdata  out  32  Avalon read data
- av_waitrequest  out  1  Avalon wait
- ram_en  out  1  RAM access enable
- ram_wr  out  1  RAM write enable
- ram_addr  out  8  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid 1 cycle after ram_en

## Operation
- JTAG capture: a jtag_req strobe latches wr, addr and wdata into a pending register.
  - If jtag_req arrives while a command is already pending or in flight, the strobe is dropped and jtag_overrun is set to 1.
  - Exception: a jtag_req in the DONE cycle of a JTAG access is accepted; it is not an overrun.
- Avalon request = av_read | av_write. The master holds the request until av_waitrequest=0. If av_read and av_write are both high, the access is a write.
- FSM states: IDLE, ACCESS, CAPTURE, DONE.
  - IDLE: if either request is present, pick the owner and register ram_addr, ram_wdata, ram_wr and ram_en=1 from the owner's fields, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: ram_en=1 for exactly this cycle; go to CAPTURE.
  - CAPTURE: ram_en=0; register ram_rdata into jtag_rdata or av_readdata, depending on owner (reads only; writes leave the data registers unchanged); go to DONE.
  - DONE: if owner=A, av_waitrequest=0 for this one cycle. If owner=J, jtag_done=1 and the pending register clears. Return to IDLE.
- Arbitration: a single requester always wins. When both request, the winner is the requester not served last. The last_owner register resets to A, so JTAG wins the first tie.
- Avalon address and data are sampled only in IDLE at grant; any changes after grant are ignored.
- av_waitrequest=1 in every cycle except DONE with owner=A.
- ram_wr is asserted only in ACCESS.

## Timing
- Reset values: state IDLE; ram_en 0; ram_wr 0; ram_addr 0; ram_wdata 0; av_readdata 0; av_waitrequest 1; jtag_rdata 0; jtag_done 0; jtag_busy 0; jtag_overrun 0; pending cleared; last_owner A.
- Latency: request seen in IDLE at cycle 0 → ram_en at cycle 1 → data captured at cycle 2 → completion (av_waitrequest=0 or jtag_done) at cycle 3.
- Throughput: one access per 4 cycles. Back-to-back tied requests alternate owners.
- jtag_busy rises the cycle after an accepted jtag_req and falls the cycle after jtag_done.
- Reset mid-operation: the FSM aborts to IDLE the next cycle. A RAM write already committed in ACCESS stays committed. No completion is signalled. The pending command is discarded.

## Configuration
- Macro `OCIMEM_WRITE_PROTECT_EN`.
  - Defined: an Avalon write with av_debugaccess=0 runs the normal 4-cycle handshake, but ram_wr stays 0 (write suppressed). Reads are unaffected.
  - Undefined: av_debugaccess is ignored and all Avalon writes commit.

## Test plan
- Reset, then idle → all outputs at their reset values; av_waitrequest=1.
- JTAG write addr 0x10, data 0xDEADBEEF, then JTAG read of 0x10 → ram_en at cycle +1, jtag_done at cycle +3 for each command, and jtag_rdata=0xDEADBEEF.
- Avalon read and jtag_req in the same cycle after reset → JTAG served first (done at +3); Avalon gets av_waitrequest=0 at +7; a further tie is then granted to JTAG.
- Second jtag_req 1 cycle after the first → jtag_overrun=1 and only one jtag_done. A jtag_req in the DONE cycle → accepted, overrun stays 0.
- Reset asserted in ACCESS of an Avalon read → IDLE next cycle, av_waitrequest=1, no completion; the held request is re-served after reset deasserts.
- With `OCIMEM_WRITE_PROTECT_EN` defined, Avalon write 0x55 to addr 3 with av_debugaccess=0 → handshake completes and ram_wr never asserts; a readback returns the prior value.

Source files
------------

// File: rtl/lights_nios2_qsys_0_ocimem_arbiter.sv
// OCI RAM arbiter: serialises JTAG debug commands and Avalon debug-slave accesses onto one RAM port.
// Optional OCIMEM_WRITE_PROTECT_EN: suppresses Avalon writes that lack av_debugaccess.
module lights_nios2_qsys_0_ocimem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        jtag_req,
    input  logic        jtag_wr,
    input  logic [7:0]  jtag_addr,
    input  logic [31:0] jtag_wdata,
    output logic [31:0] jtag_rdata,
    output logic        jtag_done,
    output logic        jtag_busy,
    output logic        jtag_overrun,
    input  logic        av_read,
    input  logic        av_write,
    input  logic [7:0]  av_address,
    input  logic [31:0] av_writedata,
    input  logic        av_debugaccess,
    output logic [31:0] av_readdata,
    output logic        av_waitrequest,
    output logic        ram_en,
    output logic        ram_wr,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    state_t      state, state_nxt;
    logic        owner_j;       // current owner, doubles as last-served owner (0 = Avalon)
    logic        cur_wr;        // logical write of the access in flight, even if suppressed
    logic        pend_valid;
    logic        pend_wr;
    logic [7:0]  pend_addr;
    logic [31:0] pend_wdata;

    logic        av_req;
    logic        j_req;
    logic        j_done_cycle;
    logic        j_accept;
    logic        j_drop;
    logic        grant_j;
    logic        j_wr_sel;
    logic [7:0]  j_addr_sel;
    logic [31:0] j_wdata_sel;
    logic        av_wr_commit;

    assign av_req       = av_read | av_write;
    assign j_done_cycle = (state == DONE) && owner_j;
    assign j_accept     = jtag_req && (!pend_valid || j_done_cycle);
    assign j_drop       = jtag_req && !j_accept;
    // A fresh strobe in IDLE competes immediately, so it is granted without a wait cycle.
    assign j_req        = pend_valid | jtag_req;
    assign grant_j      = j_req && (!av_req || !owner_j);
    assign j_wr_sel     = pend_valid ? pend_wr    : jtag_wr;
    assign j_addr_sel   = pend_valid ? pend_addr  : jtag_addr;
    assign j_wdata_sel  = pend_valid ? pend_wdata : jtag_wdata;

`ifdef OCIMEM_WRITE_PROTECT_EN
    assign av_wr_commit = av_write & av_debugaccess;
`else
    logic unused_debugaccess;
    assign unused_debugaccess = av_debugaccess;
    assign av_wr_commit = av_write;
`endif

    assign jtag_done      = j_done_cycle;
    assign jtag_busy      = pend_valid;
    assign av_waitrequest = !((state == DONE) && !owner_j);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (j_req || av_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner_j      <= 1'b0;
            cur_wr       <= 1'b0;
            pend_valid   <= 1'b0;
            pend_wr      <= 1'b0;
            pend_addr    <= 8'h00;
            pend_wdata   <= 32'h0;
            jtag_overrun <= 1'b0;
            jtag_rdata   <= 32'h0;
            av_readdata  <= 32'h0;
            ram_en       <= 1'b0;
            ram_wr       <= 1'b0;
            ram_addr     <= 8'h00;
            ram_wdata    <= 32'h0;
        end else begin
            state <= state_nxt;

            if (j_accept) begin
                pend_valid <= 1'b1;
                pend_wr    <= jtag_wr;
                pend_addr  <= jtag_addr;
                pend_wdata <= jtag_wdata;
            end else if (j_done_cycle) begin
                pend_valid <= 1'b0;
            end

            if (j_drop) jtag_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (j_req || av_req) begin
                        ram_en  <= 1'b1;
                        owner_j <= grant_j;
                        if (grant_j) begin
                            ram_addr  <= j_addr_sel;
                            ram_wdata <= j_wdata_sel;
                            ram_wr    <= j_wr_sel;
                            cur_wr    <= j_wr_sel;
                        end else begin
                            ram_addr  <= av_address;
                            ram_wdata <= av_writedata;
                            ram_wr    <= av_wr_commit;
                            cur_wr    <= av_write;
                        end
                    end
                end
                ACCESS: begin
                    ram_en <= 1'b0;
                    ram_wr <= 1'b0;
                end
                CAPTURE: begin
                    if (!cur_wr) begin
                        if (owner_j) jtag_rdata  <= ram_rdata;
                        else         av_readdata <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lights_nios2_qsys_0_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter: directed vectors, a RAM model, and a completion scoreboard.
module tb_lights_nios2_qsys_0_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        jtag_req, jtag_wr;
    logic [7:0]  jtag_addr;
    logic [31:0] jtag_wdata;
    logic [31:0] jtag_rdata;
    logic        jtag_done, jtag_busy, jtag_overrun;
    logic        av_read, av_write, av_debugaccess;
    logic [7:0]  av_address;
    logic [31:0] av_writedata, av_readdata;
    logic        av_waitrequest;
    logic        ram_en, ram_wr;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] data;
        bit          is_read;
        int          at;
    } exp_t;
    exp_t jq[$];
    exp_t aq[$];

    lights_nios2_qsys_0_ocimem_arbiter dut (
        .clk(clk), .reset(reset),
        .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
        .jtag_rdata(jtag_rdata), .jtag_done(jtag_done), .jtag_busy(jtag_busy),
        .jtag_overrun(jtag_overrun),
        .av_read(av_read), .av_write(av_write), .av_address(av_address),
        .av_writedata(av_writedata), .av_debugaccess(av_debugaccess),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 256 x 32 single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_j(input logic [31:0] d, input bit rd, input int at);
        exp_t e;
        e.data = d; e.is_read = rd; e.at = at;
        jq.push_back(e);
    endtask

    task automatic exp_a(input logic [31:0] d, input bit rd, input int at);
        exp_t e;
        e.data = d; e.is_read = rd; e.at = at;
        aq.push_back(e);
    endtask

    task automatic jtag_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d);
        jtag_req = 1'b1; jtag_wr = wr; jtag_addr = a; jtag_wdata = d;
    endtask

    // Monitor: every completion must match the head of its queue in cycle and data.
    always @(negedge clk) begin
        if (!reset) begin
            if (jtag_done) begin
                if (jq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL jtag_done_unexpected: got done at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = jq.pop_front();
                    check("jtag_done_cycle", cyc, e.at);
                    if (e.is_read) check("jtag_rdata", jtag_rdata, e.data);
                end
            end
            if (!av_waitrequest) begin
                if (aq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL av_done_unexpected: got waitrequest=0 at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = aq.pop_front();
                    check("av_done_cycle", cyc, e.at);
                    if (e.is_read) check("av_readdata", av_readdata, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int c;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1;
        jtag_req = 0; jtag_wr = 0; jtag_addr = 0; jtag_wdata = 0;
        av_read = 0; av_write = 0; av_address = 0; av_writedata = 0; av_debugaccess = 0;
        tick(3);
        reset = 1'b0;
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_wr", ram_wr, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_av_readdata", av_readdata, 0);
        check("rst_av_waitrequest", av_waitrequest, 1);
        check("rst_jtag_rdata", jtag_rdata, 0);
        check("rst_jtag_done", jtag_done, 0);
        check("rst_jtag_busy", jtag_busy, 0);
        check("rst_jtag_overrun", jtag_overrun, 0);
        tick(2);
        check("idle_av_waitrequest", av_waitrequest, 1);

        // Tie right after reset: JTAG first, Avalon four cycles later
        c = cyc;
        jtag_cmd(1, 8'h10, 32'hDEADBEEF);
        av_write = 1; av_debugaccess = 1; av_address = 8'h21; av_writedata = 32'hCAFEF00D;
        exp_j(32'h0, 0, c + 3);
        exp_a(32'h0, 0, c + 7);
        tick();
        jtag_req = 0;
        check("tie1_ram_en", ram_en, 1);
        check("tie1_ram_wr", ram_wr, 1);
        check("tie1_ram_addr", ram_addr, 8'h10);
        tick(4);
        check("tie1_av_ram_addr", ram_addr, 8'h21);
        check("tie1_av_ram_wdata", ram_wdata, 32'hCAFEF00D);
        tick(3);
        // Second tie: last served was Avalon, so JTAG wins again
        c = cyc;
        av_write = 0; av_read = 1; av_address = 8'h10;
        jtag_cmd(0, 8'h21, 32'h0);
        exp_j(32'hCAFEF00D, 1, c + 3);
        exp_a(32'hDEADBEEF, 1, c + 7);
        tick();
        jtag_req = 0;
        check("tie2_ram_addr", ram_addr, 8'h21);
        tick(7);
        av_read = 0;

        // JTAG write then read with latency checks
        c = cyc;
        jtag_cmd(1, 8'h20, 32'h12345678);
        exp_j(32'h0, 0, c + 3);
        tick();
        jtag_req = 0;
        check("jw_ram_en", ram_en, 1);
        check("jw_ram_wr", ram_wr, 1);
        check("jw_ram_wdata", ram_wdata, 32'h12345678);
        check("jw_busy", jtag_busy, 1);
        tick();
        check("jw_ram_en_off", ram_en, 0);
        tick(2);
        check("jw_busy_fall", jtag_busy, 0);
        c = cyc;
        jtag_cmd(0, 8'h20, 32'h0);
        exp_j(32'h12345678, 1, c + 3);
        tick();
        jtag_req = 0;
        check("jr_ram_wr", ram_wr, 0);
        tick(3);
        check("jr_rdata_held", jtag_rdata, 32'h12345678);

        // Strobe in the DONE cycle is accepted without overrun
        c = cyc;
        jtag_cmd(0, 8'h10, 32'h0);
        exp_j(32'hDEADBEEF, 1, c + 3);
        tick();
        jtag_req = 0;
        tick(2);
        jtag_cmd(0, 8'h20, 32'h0);
        exp_j(32'h12345678, 1, c + 7);
        tick();
        jtag_req = 0;
        check("done_accept_overrun", jtag_overrun, 0);
        check("done_accept_busy", jtag_busy, 1);
        tick(4);

        // Strobe one cycle after an accepted one is dropped
        c = cyc;
        jtag_cmd(0, 8'h21, 32'h0);
        exp_j(32'hCAFEF00D, 1, c + 3);
        tick();
        jtag_cmd(0, 8'h10, 32'h0);
        tick();
        jtag_req = 0;
        check("overrun_set", jtag_overrun, 1);
        tick(3);
        check("overrun_sticky", jtag_overrun, 1);
        check("overrun_busy_clear", jtag_busy, 0);

        // Reset during ACCESS of an Avalon read; held request is served afterwards
        c = cyc;
        av_read = 1; av_address = 8'h10;
        tick();
        check("mid_rst_ram_en", ram_en, 1);
        reset = 1;
        tick();
        reset = 0;
        check("mid_rst_ram_en_off", ram_en, 0);
        check("mid_rst_waitrequest", av_waitrequest, 1);
        check("mid_rst_overrun_clr", jtag_overrun, 0);
        check("mid_rst_jtag_rdata", jtag_rdata, 0);
        exp_a(32'hDEADBEEF, 1, c + 5);
        tick(4);
        av_read = 0;

        // Avalon write without debugaccess
        c = cyc;
        jtag_cmd(1, 8'h03, 32'h11111111);
        exp_j(32'h0, 0, c + 3);
        tick();
        jtag_req = 0;
        tick(3);
        c = cyc;
        av_write = 1; av_debugaccess = 0; av_address = 8'h03; av_writedata = 32'h00000055;
        exp_a(32'h0, 0, c + 3);
        tick();
        check("wp_ram_en", ram_en, 1);
`ifdef OCIMEM_WRITE_PROTECT_EN
        check("wp_ram_wr", ram_wr, 0);
`else
        check("wp_ram_wr", ram_wr, 1);
`endif
        tick(3);
        av_write = 0;
        c = cyc;
        av_read = 1; av_address = 8'h03;
`ifdef OCIMEM_WRITE_PROTECT_EN
        exp_a(32'h11111111, 1, c + 3);
`else
        exp_a(32'h00000055, 1, c + 3);
`endif
        tick(4);
        av_read = 0;

        tick(4);
        check("jq_drained", jq.size(), 0);
        check("aq_drained", aq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
